// File: rtl/round_controller.sv
// Round/match sequencer: frame-tick synchroniser, BCD round timer, KO/time-out
// detection, round-win tally and match winner, plus fight_en / round_rst drive.
module round_controller #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int ROUND_TIME     = 99,
    parameter int INTRO_FRAMES   = 120,
    parameter int KO_FRAMES      = 180,
    parameter int WINS_NEEDED    = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_vs,
    input  logic       start,
    input  logic [7:0] RyuHealth,
    input  logic [7:0] AkumaHealth,
    output logic       fight_en,
    output logic       round_rst,
    output logic [3:0] timer_tens,
    output logic [3:0] timer_ones,
    output logic [1:0] ryu_wins,
    output logic [1:0] akuma_wins,
    output logic [1:0] winner,
    output logic [2:0] state
);

    localparam int SUB_MAX0 = (FRAMES_PER_SEC > INTRO_FRAMES) ? FRAMES_PER_SEC : INTRO_FRAMES;
    localparam int SUB_MAX  = (SUB_MAX0 > KO_FRAMES) ? SUB_MAX0 : KO_FRAMES;
    localparam int CW       = (SUB_MAX > 1) ? $clog2(SUB_MAX) : 1;

    localparam logic [CW-1:0] FPS_LAST   = CW'(FRAMES_PER_SEC - 1);
    localparam logic [CW-1:0] INTRO_LAST = CW'(INTRO_FRAMES - 1);
    localparam logic [CW-1:0] KO_LAST    = CW'(KO_FRAMES - 1);
    localparam logic [3:0]    RT_TENS    = 4'(ROUND_TIME / 10);
    localparam logic [3:0]    RT_ONES    = 4'(ROUND_TIME % 10);
    localparam logic [1:0]    WN         = 2'(WINS_NEEDED);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INTRO = 3'd1,
        S_FIGHT = 3'd2,
        S_KO    = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    vs_sync;
    logic          tick;
    logic [CW-1:0] sub_cnt;

    logic       round_start, new_match, ko_enter, tmr_dec, sub_clr, sub_inc;
    logic [1:0] ko_winner;
    logic       ryu_ko, akuma_ko, timer_zero;

    assign ryu_ko     = (RyuHealth == 8'd0);
    assign akuma_ko   = (AkumaHealth == 8'd0);
    assign timer_zero = (timer_tens == 4'd0) && (timer_ones == 4'd0);
    assign fight_en   = (state_q == S_FIGHT);
    assign state      = state_q;

    // Two flops of synchronisation, a third for edge detect, then a registered
    // tick: the pulse lands three Clk after the raw rising edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_sync <= 3'b000;
            tick    <= 1'b0;
        end else begin
            vs_sync <= {vs_sync[1:0], frame_vs};
            tick    <= vs_sync[1] & ~vs_sync[2];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        round_start = 1'b0;
        new_match   = 1'b0;
        ko_enter    = 1'b0;
        ko_winner   = 2'b00;
        tmr_dec     = 1'b0;
        sub_clr     = 1'b0;
        sub_inc     = 1'b0;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d     = S_INTRO;
                    round_start = 1'b1;
                    new_match   = 1'b1;
                    sub_clr     = 1'b1;
                end
            end
            S_INTRO: begin
                if (tick) begin
                    if (sub_cnt == INTRO_LAST) begin
                        state_d = S_FIGHT;
                        sub_clr = 1'b1;
                    end else begin
                        sub_inc = 1'b1;
                    end
                end
            end
            S_FIGHT: begin
                // {ryu_ko, akuma_ko} maps straight onto the winner code.
                if (ryu_ko || akuma_ko) begin
                    ko_enter  = 1'b1;
                    ko_winner = {ryu_ko, akuma_ko};
                end else if (timer_zero) begin
                    ko_enter = 1'b1;
                    if (RyuHealth > AkumaHealth)      ko_winner = 2'b01;
                    else if (AkumaHealth > RyuHealth) ko_winner = 2'b10;
                    else                              ko_winner = 2'b11;
                end else if (tick) begin
                    if (sub_cnt == FPS_LAST) begin
                        tmr_dec = 1'b1;
                        sub_clr = 1'b1;
                    end else begin
                        sub_inc = 1'b1;
                    end
                end
                if (ko_enter) begin
                    state_d = S_KO;
                    sub_clr = 1'b1;
                end
            end
            S_KO: begin
                if (tick) begin
                    if (sub_cnt == KO_LAST) begin
                        sub_clr = 1'b1;
                        if (ryu_wins == WN || akuma_wins == WN) begin
                            state_d = S_OVER;
                        end else begin
                            state_d     = S_INTRO;
                            round_start = 1'b1;
                        end
                    end else begin
                        sub_inc = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sub_cnt    <= '0;
            timer_tens <= RT_TENS;
            timer_ones <= RT_ONES;
            ryu_wins   <= 2'd0;
            akuma_wins <= 2'd0;
            winner     <= 2'b00;
            round_rst  <= 1'b0;
        end else begin
            if (sub_clr)      sub_cnt <= '0;
            else if (sub_inc) sub_cnt <= sub_cnt + 1'b1;

            if (round_start) begin
                timer_tens <= RT_TENS;
                timer_ones <= RT_ONES;
                winner     <= 2'b00;
                if (new_match) begin
                    ryu_wins   <= 2'd0;
                    akuma_wins <= 2'd0;
                end
            end else if (tmr_dec && !timer_zero) begin
                if (timer_ones == 4'd0) begin
                    timer_ones <= 4'd9;
                    timer_tens <= timer_tens - 4'd1;
                end else begin
                    timer_ones <= timer_ones - 4'd1;
                end
            end

            // Winner is latched on KO entry and simply held through MATCH_OVER.
            if (ko_enter) begin
                winner <= ko_winner;
                if (ko_winner == 2'b01 && ryu_wins != WN)   ryu_wins   <= ryu_wins + 2'd1;
                if (ko_winner == 2'b10 && akuma_wins != WN) akuma_wins <= akuma_wins + 2'd1;
            end

            if (round_start)  round_rst <= 1'b1;
            else if (tick)    round_rst <= 1'b0;
        end
    end

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with short frame/round parameters.
module tb_round_controller;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_vs;
    logic       start;
    logic [7:0] RyuHealth, AkumaHealth;
    logic       fight_en, round_rst;
    logic [3:0] timer_tens, timer_ones;
    logic [1:0] ryu_wins, akuma_wins, winner;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    round_controller #(
        .FRAMES_PER_SEC(2), .ROUND_TIME(3), .INTRO_FRAMES(2),
        .KO_FRAMES(2), .WINS_NEEDED(2)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_vs(frame_vs), .start(start),
        .RyuHealth(RyuHealth), .AkumaHealth(AkumaHealth),
        .fight_en(fight_en), .round_rst(round_rst),
        .timer_tens(timer_tens), .timer_ones(timer_ones),
        .ryu_wins(ryu_wins), .akuma_wins(akuma_wins),
        .winner(winner), .state(state)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic frame_tick();
        @(negedge Clk) frame_vs = 1'b1;
        repeat (4) @(negedge Clk);
        frame_vs = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) frame_tick();
    endtask

    task automatic pulse_start();
        @(negedge Clk) start = 1'b1;
        @(negedge Clk) start = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0; frame_vs = 1'b0; start = 1'b0;
        RyuHealth = 8'd100; AkumaHealth = 8'd100;
        repeat (3) @(negedge Clk);
        check("rst_state", state, 3'd0);
        check("rst_timer", {timer_tens, timer_ones}, 8'h03);
        check("rst_wins", {ryu_wins, akuma_wins}, 4'h0);
        check("rst_winner", winner, 2'b00);
        check("rst_fight_en", fight_en, 1'b0);
        check("rst_round_rst", round_rst, 1'b0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Round 1: start, measure tick latency via round_rst release.
        pulse_start();
        check("start_state", state, 3'd1);
        check("start_round_rst", round_rst, 1'b1);
        check("start_fight_en", fight_en, 1'b0);
        frame_vs = 1'b1;
        repeat (3) @(negedge Clk);
        check("rr_held_3clk", round_rst, 1'b1);
        @(negedge Clk);
        check("rr_drop_4clk", round_rst, 1'b0);
        check("intro_after_1tick", state, 3'd1);
        frame_vs = 1'b0;
        repeat (4) @(negedge Clk);
        frame_tick();
        check("fight_state", state, 3'd2);
        check("fight_en", fight_en, 1'b1);

        RyuHealth = 8'd50; AkumaHealth = 8'd40;
        ticks(2);
        check("timer_02", {timer_tens, timer_ones}, 8'h02);
        ticks(4);
        check("timeout_state", state, 3'd3);
        check("timeout_winner", winner, 2'b01);
        check("timeout_ryu_wins", ryu_wins, 2'd1);
        check("timeout_timer", {timer_tens, timer_ones}, 8'h00);
        check("ko_fight_en", fight_en, 1'b0);
        frame_tick();
        check("ko_timer_frozen", {timer_tens, timer_ones}, 8'h00);
        frame_tick();
        check("r2_intro", state, 3'd1);
        check("r2_winner_clr", winner, 2'b00);
        check("r2_timer", {timer_tens, timer_ones}, 8'h03);
        check("r2_round_rst", round_rst, 1'b1);
        check("r2_ryu_wins_kept", ryu_wins, 2'd1);

        // Round 2: Akuma KO on the tick that zeroes the timer.
        ticks(2);
        check("r2_fight", state, 3'd2);
        ticks(5);
        check("r2_timer_01", {timer_tens, timer_ones}, 8'h01);
        @(negedge Clk) frame_vs = 1'b1;
        repeat (3) @(negedge Clk);
        AkumaHealth = 8'd0;
        @(negedge Clk);
        check("r2_ko_state", state, 3'd3);
        check("r2_ko_winner", winner, 2'b01);
        check("r2_ryu_wins", ryu_wins, 2'd2);
        frame_vs = 1'b0;
        AkumaHealth = 8'd40;
        repeat (4) @(negedge Clk);
        ticks(2);
        check("match_over", state, 3'd4);
        check("match_winner", winner, 2'b01);
        check("match_ryu_wins", ryu_wins, 2'd2);
        pulse_start();
        check("restart_state", state, 3'd1);
        check("restart_wins", {ryu_wins, akuma_wins}, 4'h0);
        check("restart_timer", {timer_tens, timer_ones}, 8'h03);
        check("restart_winner", winner, 2'b00);

        // Draw: both healths zero on the same Clk.
        ticks(2);
        RyuHealth = 8'd100; AkumaHealth = 8'd100;
        @(negedge Clk);
        RyuHealth = 8'd0; AkumaHealth = 8'd0;
        @(negedge Clk);
        check("draw_state", state, 3'd3);
        check("draw_winner", winner, 2'b11);
        check("draw_wins", {ryu_wins, akuma_wins}, 4'h0);
        RyuHealth = 8'd100; AkumaHealth = 8'd100;
        ticks(2);
        check("draw_next_intro", state, 3'd1);
        check("draw_rr_set", round_rst, 1'b1);
        @(negedge Clk) frame_vs = 1'b1;
        repeat (3) @(negedge Clk);
        check("draw_rr_span", round_rst, 1'b1);
        @(negedge Clk);
        check("draw_rr_drop", round_rst, 1'b0);
        frame_vs = 1'b0;
        repeat (4) @(negedge Clk);
        frame_tick();

        // Akuma wins by Ryu KO, then start is ignored mid-FIGHT.
        @(negedge Clk) RyuHealth = 8'd0;
        @(negedge Clk);
        check("akuma_ko_winner", winner, 2'b10);
        check("akuma_ko_wins", {ryu_wins, akuma_wins}, 4'b0001);
        RyuHealth = 8'd100;
        ticks(4);
        check("r5_fight", state, 3'd2);
        pulse_start();
        check("start_ignored", state, 3'd2);

        // Asynchronous reset mid-FIGHT.
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("arst_state", state, 3'd0);
        check("arst_timer", {timer_tens, timer_ones}, 8'h03);
        check("arst_wins", {ryu_wins, akuma_wins}, 4'h0);
        check("arst_fight_en", fight_en, 1'b0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
